// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
//
// Contents:
//   DIV_ITERS    - number of restoring-division iterations (fixed at 32)
//   mdu_op_t     - 3-bit operation encoding driven on muldiv_unit.op
//   mdu_state_t  - muldiv_unit control FSM states
//   op_legal / op_is_mul / op_is_div / op_is_signed - opcode decode helpers
//
// Configuration macro: MULDIV_MADD_EN
//   When defined, the MADD/MADDU/MSUB/MSUBU encodings decode as multiplies.
//   When undefined, those encodings are illegal and treated as no-ops.
//
// The 32-bit word type (word_t) lives in common.svh; plain logic [31:0] is
// used here so this slice stands on its own.

package mdu_pkg;

    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } mdu_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        WB   = 3'd4
    } mdu_state_t;

    // Multiply-class op (uses the multiplier pipeline and MUL_LATENCY timing).
    function automatic logic op_is_mul(input mdu_op_t op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Divide-class op (uses the iterative divider).
    function automatic logic op_is_div(input mdu_op_t op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops that do any work; everything else is accepted as a silent no-op.
    function automatic logic op_legal(input mdu_op_t op);
        return op_is_mul(op) | op_is_div(op);
    endfunction

    // Ops whose operands are treated as two's-complement.
    function automatic logic op_is_signed(input mdu_op_t op);
        logic r;
        case (op)
            OP_MULT, OP_DIV, OP_MADD, OP_MSUB: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative 32-bit unsigned restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   start               load operands; the first iteration is performed on
//                       the same edge, so DIV_ITERS-1 further edges finish it
//   dividend, divisor   unsigned operands, sampled only when start=1
//   done                high in the cycle whose closing edge performs the
//                       final iteration; quotient/remainder are final from
//                       the following cycle until the next start
//   quotient, remainder unsigned results
//
// Divide by zero needs no special case: every trial subtraction succeeds,
// giving quotient 0xFFFFFFFF and the dividend shifted out as the remainder.

module div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dsr_r;
    logic [5:0]  cnt_r;
    logic [63:0] step_s;
    logic        iterate_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // Invariant rem < dsr keeps the restored/subtracted remainder within 32 bits.
    function automatic logic [63:0] restore_step(input logic [31:0] rem,
                                                 input logic [31:0] quo,
                                                 input logic [31:0] dsr);
        logic [32:0] shifted;
        logic        ge;
        logic [31:0] rem_n;
        shifted = {rem, quo[31]};
        ge      = (shifted >= {1'b0, dsr});
        rem_n   = ge ? 32'(shifted - {1'b0, dsr}) : shifted[31:0];
        return {rem_n, quo[30:0], ge};
    endfunction

    assign iterate_s = (cnt_r != 6'd0) && (cnt_r != 6'(DIV_ITERS));

    // Next {remainder, quotient}: start seeds from a zero partial remainder.
    always_comb begin
        step_s = 64'd0;
        if (start) begin
            step_s = restore_step(32'd0, dividend, divisor);
        end else begin
            step_s = restore_step(rem_r, quo_r, dsr_r);
        end
    end

    // Iteration registers; cnt_r counts completed iterations and parks at DIV_ITERS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            dsr_r <= 32'd0;
            cnt_r <= 6'd0;
        end else if (start) begin
            rem_r <= step_s[63:32];
            quo_r <= step_s[31:0];
            dsr_r <= divisor;
            cnt_r <= 6'd1;
        end else if (iterate_s) begin
            rem_r <= step_s[63:32];
            quo_r <= step_s[31:0];
            cnt_r <= cnt_r + 6'd1;
        end
    end

    assign done      = (cnt_r == 6'(DIV_ITERS - 1));
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; sole producer of HI/LO writes.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   valid, op              op request, sampled only while busy==0
//   src_a, src_b           rs / rt operands
//   flush                  abort the in-flight op (no HI/LO write)
//   hi_in, lo_in           current HI/LO, used by the accumulate ops only
//   busy                   op in flight, no new accept
//   write_hi_en/_lo_en     one-cycle HI/LO write strobes
//   hi_data, lo_data       product[63:32]/[31:0] or remainder/quotient
//
// Parameter MUL_LATENCY (1..4): cycles from accept to write for multiplies.
// Divides take 33 cycles: 32 restoring iterations (the first on the accept
// edge) then one FIX cycle that applies signs and registers the result.
//
// Configuration macro: MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate into {hi_in, lo_in} sampled in cycle N-1.

module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int MUL_LATENCY = 2
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  mdu_op_t     op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic        busy,
    output logic        write_hi_en,
    output logic        write_lo_en,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data
);

    mdu_state_t  state_r, state_n;
    logic [2:0]  mul_cnt_r, mul_cnt_n;
    logic        busy_r;
    logic        wr_r, wr_n;
    logic [31:0] hi_r, hi_n;
    logic [31:0] lo_r, lo_n;
    logic        sa_r, sb_r;

    logic        accept_s;
    logic        signed_s;
    logic [63:0] mul_a_s, mul_b_s, prod_now_s;
    logic [63:0] mul_prod_s;
    logic [63:0] mul_res_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic        div_start_s;
    logic        div_done_s;
    logic [31:0] div_q_s, div_r_s;
    logic [31:0] quo_fix_s, rem_fix_s;

    assign accept_s = valid && !busy_r && !flush && op_legal(op);
    assign signed_s = op_is_signed(op);

    // Operands extended to 64 bits; the low 64 bits of this product equal the
    // low 64 bits of the 33x33 signed product.
    always_comb begin
        mul_a_s    = signed_s ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
        mul_b_s    = signed_s ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
        prod_now_s = mul_a_s * mul_b_s;
    end

    generate
        if (MUL_LATENCY == 1) begin : g_no_retime
            assign mul_prod_s = prod_now_s;
        end else begin : g_retime
            logic [63:0] pipe_r [0:MUL_LATENCY-2];

            // Free-running retiming chain; only one op is in flight, so the
            // value captured on the accept edge reaches the end in time.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < MUL_LATENCY - 1; i++) begin
                        pipe_r[i] <= 64'd0;
                    end
                end else begin
                    pipe_r[0] <= prod_now_s;
                    for (int i = 1; i < MUL_LATENCY - 1; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end

            assign mul_prod_s = pipe_r[MUL_LATENCY-2];
        end
    endgenerate

`ifdef MULDIV_MADD_EN
    mdu_op_t op_r;
    mdu_op_t mul_op_s;

    // Opcode of the multiply in flight, needed to pick accumulate/subtract.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_r <= OP_MULT;
        end else if (accept_s) begin
            op_r <= op;
        end
    end

    assign mul_op_s = (MUL_LATENCY == 1) ? op : op_r;

    // Final multiply result; accumulate ops read HI/LO combinationally in cycle N-1.
    always_comb begin
        mul_res_s = mul_prod_s;
        case (mul_op_s)
            OP_MADD, OP_MADDU: mul_res_s = {hi_in, lo_in} + mul_prod_s;
            OP_MSUB, OP_MSUBU: mul_res_s = {hi_in, lo_in} - mul_prod_s;
            default:           mul_res_s = mul_prod_s;
        endcase
    end
`else
    logic unused_hilo_s;

    assign unused_hilo_s = ^{hi_in, lo_in};
    assign mul_res_s     = mul_prod_s;
`endif

    // Divider operand magnitudes; only DIV treats operands as signed.
    always_comb begin
        mag_a_s = (op == OP_DIV && src_a[31]) ? (32'd0 - src_a) : src_a;
        mag_b_s = (op == OP_DIV && src_b[31]) ? (32'd0 - src_b) : src_b;
    end

    div_radix2 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start_s),
        .dividend  (mag_a_s),
        .divisor   (mag_b_s),
        .done      (div_done_s),
        .quotient  (div_q_s),
        .remainder (div_r_s)
    );

    // Sign fix: quotient negative when operand signs differ, remainder takes the dividend's sign.
    always_comb begin
        quo_fix_s = (sa_r ^ sb_r) ? (32'd0 - div_q_s) : div_q_s;
        rem_fix_s = sa_r ? (32'd0 - div_r_s) : div_r_s;
    end

    // Next-state and next-output logic; WB behaves like IDLE so ops can issue back-to-back.
    always_comb begin
        state_n     = state_r;
        mul_cnt_n   = mul_cnt_r;
        wr_n        = 1'b0;
        hi_n        = hi_r;
        lo_n        = lo_r;
        div_start_s = 1'b0;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE, WB: begin
                    if (accept_s && op_is_div(op)) begin
                        state_n     = DIV;
                        div_start_s = 1'b1;
                    end else if (accept_s) begin
                        if (MUL_LATENCY == 1) begin
                            state_n = WB;
                            wr_n    = 1'b1;
                            hi_n    = mul_res_s[63:32];
                            lo_n    = mul_res_s[31:0];
                        end else begin
                            state_n   = MUL;
                            mul_cnt_n = 3'd1;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                MUL: begin
                    if (mul_cnt_r == 3'(MUL_LATENCY - 1)) begin
                        state_n = WB;
                        wr_n    = 1'b1;
                        hi_n    = mul_res_s[63:32];
                        lo_n    = mul_res_s[31:0];
                    end else begin
                        mul_cnt_n = mul_cnt_r + 3'd1;
                    end
                end
                DIV: begin
                    // done fires while the last iteration is being clocked,
                    // so FIX sees the final magnitudes.
                    if (div_done_s) begin
                        state_n = FIX;
                    end else begin
                        state_n = DIV;
                    end
                end
                FIX: begin
                    state_n = WB;
                    wr_n    = 1'b1;
                    hi_n    = rem_fix_s;
                    lo_n    = quo_fix_s;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            mul_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_n;
            mul_cnt_r <= mul_cnt_n;
        end
    end

    // Registered outputs and captured divide signs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r <= 1'b0;
            wr_r   <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            sa_r   <= 1'b0;
            sb_r   <= 1'b0;
        end else begin
            busy_r <= (state_n == MUL) || (state_n == DIV) || (state_n == FIX);
            wr_r   <= wr_n;
            hi_r   <= hi_n;
            lo_r   <= lo_n;
            if (div_start_s) begin
                sa_r <= (op == OP_DIV) && src_a[31];
                sb_r <= (op == OP_DIV) && src_b[31];
            end
        end
    end

    assign busy        = busy_r;
    assign write_hi_en = wr_r;
    assign write_lo_en = wr_r;
    assign hi_data     = hi_r;
    assign lo_data     = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed ops push their expected
// {hi, lo} into a queue; a monitor pops and compares on every write strobe.
// Cycle-accurate busy/strobe timing is checked alongside the stimulus.

module tb_muldiv_unit;
    import mdu_pkg::*;

    localparam int ML = 2;
    localparam int DN = DIV_ITERS + 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    mdu_op_t     op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic [31:0] hi_in, lo_in;
    logic        busy, write_hi_en, write_lo_en;
    logic [31:0] hi_data, lo_data;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    muldiv_unit #(.MUL_LATENCY(ML)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (valid),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .hi_in       (hi_in),
        .lo_in       (lo_in),
        .busy        (busy),
        .write_hi_en (write_hi_en),
        .write_lo_en (write_lo_en),
        .hi_data     (hi_data),
        .lo_data     (lo_data)
    );

    task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding op.
    always @(negedge clk) begin
        if (write_hi_en === 1'b1 || write_lo_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got hi=%h lo=%h expected no write", hi_data, lo_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check1("result", {hi_data, lo_data}, mon_exp);
                check1("strobe_pair", {63'd0, write_hi_en & write_lo_en}, 64'd1);
            end
        end
    end

    // Check busy/strobes mid-cycle, then advance to just after the next edge.
    task automatic cyc(input logic eb, input logic ew, input string nm);
        @(negedge clk);
        check1({nm, "_busy"}, {63'd0, busy}, {63'd0, eb});
        check1({nm, "_wr_hi"}, {63'd0, write_hi_en}, {63'd0, ew});
        check1({nm, "_wr_lo"}, {63'd0, write_lo_en}, {63'd0, ew});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        src_a = a;
        src_b = b;
        valid = 1'b1;
    endtask

    task automatic do_op(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input int n, input string nm);
        exp_q.push_back(e);
        drive(o, a, b);
        cyc(1'b0, 1'b0, {nm, "_c0"});
        valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            cyc(k < n, k == n, nm);
        end
    endtask

    initial begin
        resetn = 1'b0;
        valid  = 1'b0;
        flush  = 1'b0;
        op     = OP_MULT;
        src_a  = 32'd0;
        src_b  = 32'd0;
        hi_in  = 32'd0;
        lo_in  = 32'd0;
        #12;
        check1("rst_busy", {63'd0, busy}, 64'd0);
        check1("rst_wr", {62'd0, write_hi_en, write_lo_en}, 64'd0);
        check1("rst_data", {hi_data, lo_data}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Multiplies
        do_op(OP_MULT,  32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, ML, "mult_neg");
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, ML, "multu_max");
        do_op(OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, ML, "mult_min");

        // Divides, including divide-by-zero and the overflow case
        do_op(OP_DIVU, 32'd100,      32'd7,        64'h00000002_0000000E, DN, "divu_100_7");
        do_op(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, DN, "div_m7_2");
        do_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DN, "div_ovf");
        do_op(OP_DIVU, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, DN, "divu_by0");
        do_op(OP_DIV,  32'hFFFFFFF8, 32'd0,        64'hFFFFFFF8_00000001, DN, "div_neg_by0");

        // Flush in cycle 10 of a DIV; a MULT offered while busy must be ignored
        drive(OP_DIV, 32'd100, 32'd7);
        cyc(1'b0, 1'b0, "fl_c0");
        valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin
                drive(OP_MULT, 32'd3, 32'd3);
            end else begin
                valid = 1'b0;
            end
            cyc(1'b1, 1'b0, "fl_busy");
        end
        valid = 1'b0;
        flush = 1'b1;
        cyc(1'b1, 1'b0, "fl_c10");
        flush = 1'b0;
        exp_q.push_back(64'h00000001_23456780);
        drive(OP_MULTU, 32'h12345678, 32'h00000010);
        cyc(1'b0, 1'b0, "fl_c11");
        valid = 1'b0;
        cyc(1'b1, 1'b0, "fl_c12");
        cyc(1'b0, 1'b1, "fl_c13");
        cyc(1'b0, 1'b0, "fl_c14");

        // Flush in the accept cycle discards the op
        drive(OP_MULT, 32'd3, 32'd3);
        flush = 1'b1;
        cyc(1'b0, 1'b0, "flacc_c0");
        valid = 1'b0;
        flush = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b0, "flacc_idle");
        end

        // Back-to-back: MULTU accepted in the DIVU write cycle
        exp_q.push_back(64'h00000002_0000000E);
        drive(OP_DIVU, 32'd100, 32'd7);
        cyc(1'b0, 1'b0, "b2b_c0");
        valid = 1'b0;
        for (int k = 1; k < DN; k++) begin
            cyc(1'b1, 1'b0, "b2b_div");
        end
        exp_q.push_back(64'h00000000_0000002A);
        drive(OP_MULTU, 32'd7, 32'd6);
        cyc(1'b0, 1'b1, "b2b_c33");
        valid = 1'b0;
        cyc(1'b1, 1'b0, "b2b_c34");
        cyc(1'b0, 1'b1, "b2b_c35");
        cyc(1'b0, 1'b0, "b2b_c36");

        // Reset pulsed mid-DIV: outputs clear at once, no strobe afterwards
        drive(OP_DIV, 32'hFFFFFFF9, 32'd2);
        cyc(1'b0, 1'b0, "rdiv_c0");
        valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b0, "rdiv_busy");
        end
        resetn = 1'b0;
        #1;
        check1("rmid_busy", {63'd0, busy}, 64'd0);
        check1("rmid_wr", {62'd0, write_hi_en, write_lo_en}, 64'd0);
        check1("rmid_data", {hi_data, lo_data}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'b0, "rmid_quiet");
        end

        do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, DN, "div_7_m2");

        // Accumulate ops
        hi_in = 32'h00000000;
        lo_in = 32'hFFFFFFFF;
`ifdef MULDIV_MADD_EN
        do_op(OP_MADDU, 32'd1, 32'd1, 64'h00000001_00000000, ML, "maddu");
        hi_in = 32'h00000000;
        lo_in = 32'h00000000;
        do_op(OP_MSUB, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, ML, "msub");
`else
        drive(OP_MADDU, 32'd1, 32'd1);
        cyc(1'b0, 1'b0, "maddu_off_c0");
        valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0, "maddu_off");
        end
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
